// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg
// Shared definitions for the sequential RISC-V M-extension divider.
//   - Operation encodings carried on req_op.
//   - Sequencer state enum.
//   - Iteration counter width.
//   - Small helpers that classify an operation code.
// ============================================================================
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Wide enough to count XLEN = 32 iterations.
    localparam int DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

    // DIV and REM treat their operands as two's complement.
    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic isRemOp(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_operand_prep.sv
// ============================================================================
// div_operand_prep
// Combinational operand conditioning for the divider.
// Ports:
//   i_op        : operation code (DIV/DIVU/REM/REMU)
//   i_a, i_b    : raw dividend and divisor
//   o_absA      : |a| for signed ops, a for unsigned ops
//   o_absB      : |b| for signed ops, b for unsigned ops
//   o_negQuot   : quotient must be negated (operand signs differ)
//   o_negRem    : remainder must be negated (dividend negative)
//   o_divZero   : divisor is zero
//   o_overflow  : signed most-negative / -1 case
// ============================================================================
module div_operand_prep
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_absA,
    output logic [XLEN-1:0] o_absB,
    output logic            o_negQuot,
    output logic            o_negRem,
    output logic            o_divZero,
    output logic            o_overflow
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic w_signedOp;
    logic w_aNeg;
    logic w_bNeg;

    // Work out operand signs and magnitudes. Negating the most-negative value
    // yields the same bit pattern, which is exactly its unsigned magnitude.
    always_comb begin
        w_signedOp = isSignedOp(i_op);
        w_aNeg     = w_signedOp & i_a[XLEN-1];
        w_bNeg     = w_signedOp & i_b[XLEN-1];
        o_absA     = w_aNeg ? -i_a : i_a;
        o_absB     = w_bNeg ? -i_b : i_b;
        o_negQuot  = w_aNeg ^ w_bNeg;
        o_negRem   = w_aNeg;
        o_divZero  = (i_b == '0);
        o_overflow = w_signedOp && (i_a == MIN_VAL) && (i_b == '1);
    end

endmodule

// File: rtl/div_seq.sv
// ============================================================================
// div_seq
// Multi-cycle DIV/DIVU/REM/REMU sequencer. Runs restoring division, one
// quotient bit per cycle, over an external shared combinational adder.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : abort current operation, return to IDLE
//   req_valid/req_ready     : issue handshake; req_op/req_a/req_b operands
//   resp_valid/resp_ready   : writeback handshake; resp_data result
//   busy                    : sequencer not in IDLE
//   add_x/add_y/add_cin     : operands driven to the shared adder
//   add_f/add_cout          : sum and carry returned by the shared adder
// Build option:
//   DIV_SEQ_EARLY_OUT_EN    : when defined, PREP compares |a| with |b| on the
//                             adder and finishes early when |a| < |b|.
// ============================================================================
module div_seq
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    output logic [XLEN-1:0] add_x,
    output logic [XLEN-1:0] add_y,
    output logic            add_cin,
    input  logic [XLEN-1:0] add_f,
    input  logic            add_cout
);

    localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(XLEN - 1);

    div_state_t            r_state;
    logic [1:0]            r_op;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic [XLEN-1:0]       r_div;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_quot;
    logic [DIV_CNT_W-1:0]  r_cnt;
    logic                  r_negQuot;
    logic                  r_negRem;
    logic [XLEN-1:0]       r_respData;

    logic [XLEN-1:0]       w_absA;
    logic [XLEN-1:0]       w_absB;
    logic                  w_negQuot;
    logic                  w_negRem;
    logic                  w_divZero;
    logic                  w_overflow;
    logic [XLEN-1:0]       w_shifted;
    logic                  w_qBit;
    logic [XLEN-1:0]       w_selResult;
    logic                  w_selNeg;
    logic [XLEN-1:0]       w_fixResult;

    div_operand_prep #(.XLEN(XLEN)) u_prep (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_absA     (w_absA),
        .o_absB     (w_absB),
        .o_negQuot  (w_negQuot),
        .o_negRem   (w_negRem),
        .o_divZero  (w_divZero),
        .o_overflow (w_overflow)
    );

    // Datapath helpers. The dividend is shifted out of the top of r_quot while
    // quotient bits fill in from the bottom. If the remainder's top bit is set,
    // the shifted value exceeds XLEN bits and is certainly >= the divisor, so
    // the subtraction is taken even though the adder carry cannot show it.
    always_comb begin
        w_shifted   = {r_rem[XLEN-2:0], r_quot[XLEN-1]};
        w_qBit      = add_cout | r_rem[XLEN-1];
        w_selResult = isRemOp(r_op) ? r_rem : r_quot;
        w_selNeg    = isRemOp(r_op) ? r_negRem : r_negQuot;
        w_fixResult = w_selNeg ? add_f : w_selResult;
    end

    // Drive the shared adder only in the states that need it; zeros otherwise
    // so the adder sees quiet inputs while the divider is idle.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (r_state)
`ifdef DIV_SEQ_EARLY_OUT_EN
            ST_PREP: begin
                add_x   = w_absA;
                add_y   = ~w_absB;
                add_cin = 1'b1;
            end
`endif
            ST_ITER: begin
                add_x   = w_shifted;
                add_y   = ~r_div;
                add_cin = 1'b1;
            end
            ST_FIX: begin
                if (w_selNeg) begin
                    add_x   = '0;
                    add_y   = ~w_selResult;
                    add_cin = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Main sequencer. Flush overrides everything and returns to IDLE. Special
    // cases resolved in PREP load their final values with negation disabled
    // and pass through FIX, which is the single place the response register
    // is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= DIV_OP_DIV;
            r_a        <= '0;
            r_b        <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_negQuot  <= 1'b0;
            r_negRem   <= 1'b0;
            r_respData <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_negQuot <= 1'b0;
                    r_negRem  <= 1'b0;
                    if (w_divZero) begin
                        r_quot  <= '1;
                        r_rem   <= r_a;
                        r_state <= ST_FIX;
                    end else if (w_overflow) begin
                        r_quot  <= r_a;
                        r_rem   <= '0;
                        r_state <= ST_FIX;
`ifdef DIV_SEQ_EARLY_OUT_EN
                    end else if (!add_cout) begin
                        r_quot  <= '0;
                        r_rem   <= r_a;
                        r_state <= ST_FIX;
`endif
                    end else begin
                        r_negQuot <= w_negQuot;
                        r_negRem  <= w_negRem;
                        r_quot    <= w_absA;
                        r_div     <= w_absB;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_state   <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_rem  <= w_qBit ? add_f : w_shifted;
                    r_quot <= {r_quot[XLEN-2:0], w_qBit};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_respData <= w_fixResult;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE) && !flush;
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_DONE);
    assign resp_data  = r_respData;

endmodule
